// File: rtl/dc_pkg.sv
// dc_pkg: shared widths, tag bit positions and FSM state encoding for the lookup master.
package dc_pkg;
    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 512;
    localparam int TAG_S     = 64;
    localparam int ID_W      = 16;
    localparam int INDEX_W   = 26;
    localparam int OFFSET_W  = 6;
    localparam int BLANK_W   = 30;
    localparam int TAG_VALID = 63;
    localparam int TAG_DIRTY = 62;
    localparam int TAG_MSB   = 61;
    localparam int TAG_LSB   = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_RSP
    } state_t;
endpackage

// File: rtl/dc_tag_cmp.sv
// dc_tag_cmp: combinational hit detect; valid bit set and stored tag equals the address upper half.
module dc_tag_cmp
    import dc_pkg::*;
(
    input  logic [TAG_S-1:0]  tag_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o
);
    assign hit_o = tag_i[TAG_VALID] && (tag_i[TAG_MSB:TAG_LSB] == addr_i[ADDR_W-1:INDEX_W+OFFSET_W]);

    // Dirty and blank bits never take part in the compare.
    logic unused_bits;
    assign unused_bits = ^{tag_i[TAG_DIRTY], tag_i[BLANK_W-1:0], addr_i[INDEX_W+OFFSET_W-1:0]};
endmodule

// File: rtl/dc_lookup_master.sv
// dc_lookup_master: single-outstanding AXI lookup/write master for the data cache.
// Define DC_LOOKUP_STATS_EN to add saturating hit/miss counters on completed reads.
module dc_lookup_master
    import dc_pkg::*;
#(
    parameter int unsigned AXI_ID = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic [DATA_W-1:0]       req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_hit_o,
    output logic [DATA_W-1:0]       rsp_data_o,
    output logic [ID_W-1:0]         arid_o,
    output logic [ADDR_W-1:0]       araddr_o,
    output logic                    arvalid_o,
    input  logic                    arready_i,
    input  logic [ID_W-1:0]         rid_i,
    input  logic [TAG_S+DATA_W-1:0] rdata_i,
    input  logic                    rvalid_i,
    output logic                    rready_o,
    output logic [ID_W-1:0]         awid_o,
    output logic [ADDR_W-1:0]       awaddr_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [ID_W-1:0]         wid_o,
    output logic [DATA_W-1:0]       wdata_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [ID_W-1:0]         bid_i,
    input  logic                    bvalid_i,
    output logic                    bready_o
`ifdef DC_LOOKUP_STATS_EN
    ,
    output logic [31:0]             hit_cnt_o,
    output logic [31:0]             miss_cnt_o
`endif
);
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                hit_q, hit_d;
    logic                hit;

    dc_tag_cmp u_tag_cmp (
        .tag_i  (rdata_i[TAG_S+DATA_W-1:DATA_W]),
        .addr_i (addr_q),
        .hit_o  (hit)
    );

    // data_q carries the write payload, then is reused to hold the response line.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        hit_d   = hit_q;
        case (state_q)
            ST_IDLE: if (req_valid_i) begin
                addr_d  = req_addr_i;
                data_d  = req_wdata_i;
                state_d = req_write_i ? ST_AW : ST_AR;
            end
            ST_AR:   if (arready_i) state_d = ST_R;
            ST_R:    if (rvalid_i) begin
                hit_d   = hit;
                data_d  = hit ? rdata_i[DATA_W-1:0] : '0;
                state_d = ST_RSP;
            end
            ST_AW:   if (awready_i) state_d = ST_W;
            ST_W:    if (wready_i) state_d = ST_B;
            ST_B:    if (bvalid_i) begin
                hit_d   = 1'b1;
                state_d = ST_RSP;
            end
            ST_RSP:  if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hit_q   <= hit_d;
        end
    end

    assign req_ready_o = state_q == ST_IDLE;
    assign arvalid_o   = state_q == ST_AR;
    assign rready_o    = state_q == ST_R;
    assign awvalid_o   = state_q == ST_AW;
    assign wvalid_o    = state_q == ST_W;
    assign bready_o    = state_q == ST_B;
    assign rsp_valid_o = state_q == ST_RSP;
    assign araddr_o    = arvalid_o ? addr_q : '0;
    assign awaddr_o    = awvalid_o ? addr_q : '0;
    assign arid_o      = arvalid_o ? ID_W'(AXI_ID) : '0;
    assign awid_o      = awvalid_o ? ID_W'(AXI_ID) : '0;
    assign wid_o       = wvalid_o ? ID_W'(AXI_ID) : '0;
    assign wdata_o     = wvalid_o ? data_q : '0;
    assign rsp_hit_o   = rsp_valid_o & hit_q;
    assign rsp_data_o  = rsp_valid_o ? data_q : '0;

    logic unused_ids;
    assign unused_ids = ^{rid_i, bid_i};

`ifdef DC_LOOKUP_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic        rd_done;

    assign rd_done = (state_q == ST_R) && rvalid_i;

    always_comb begin
        hit_cnt_d  = (rd_done && hit && ~&hit_cnt_q) ? hit_cnt_q + 32'd1 : hit_cnt_q;
        miss_cnt_d = (rd_done && !hit && ~&miss_cnt_q) ? miss_cnt_q + 32'd1 : miss_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dc_lookup_master.sv
// tb_dc_lookup_master: directed and random transactions against an index-addressed cache slave model.
module tb_dc_lookup_master;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0, req_write = 1'b0;
    logic [63:0]  req_addr = '0;
    logic [511:0] req_wdata = '0;
    logic         rsp_ready = 1'b0, arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [575:0] rdata = '0;
    logic [15:0]  rid = 16'h5, bid = 16'h6;
    logic         req_ready_o, rsp_valid_o, rsp_hit_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o;
    logic [511:0] rsp_data_o, wdata_o;
    logic [63:0]  araddr_o, awaddr_o;
    logic [15:0]  arid_o, awid_o, wid_o;
`ifdef DC_LOOKUP_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    int n_chk = 0, n_fail = 0;
    int exp_hits = 0, exp_misses = 0;
    logic [575:0] mem [int];

    dc_lookup_master #(.AXI_ID(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit_o), .rsp_data_o(rsp_data_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready),
        .rid_i(rid), .rdata_i(rdata), .rvalid_i(rvalid), .rready_o(rready_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready),
        .wid_o(wid_o), .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready),
        .bid_i(bid), .bvalid_i(bvalid), .bready_o(bready_o)
`ifdef DC_LOOKUP_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_stats();
`ifdef DC_LOOKUP_STATS_EN
        check("hit_cnt", hit_cnt_o, exp_hits);
        check("miss_cnt", miss_cnt_o, exp_misses);
`endif
    endtask

    // Slave entries are selected by line index; the model decides hit/miss from the stored tag word.
    task automatic txn(input bit wr, input logic [63:0] addr, input logic [511:0] wd,
                       input int ar_w, input int r_w, input int aw_w, input int w_w, input int b_w, input int rsp_w);
        int idx;
        logic [575:0] ent;
        bit exp_hit;
        logic [511:0] exp_data;
        int exp_lat;
        int lat;
        bit aw_done, b_seen, done;
        idx = int'(addr[31:6]);
        ent = mem.exists(idx) ? mem[idx] : '0;
        lat = -1;
        aw_done = 0;
        b_seen = 0;
        done = 0;
        if (wr) begin
            exp_hit = 1;
            exp_data = wd;
            exp_lat = 4 + aw_w + w_w + b_w;
        end else begin
            exp_hit = ent[575] && (ent[573:542] == addr[63:32]);
            exp_data = exp_hit ? ent[511:0] : '0;
            exp_lat = 3 + ar_w + r_w;
            if (exp_hit) exp_hits++; else exp_misses++;
        end
        req_valid = 1;
        req_write = wr;
        req_addr = addr;
        req_wdata = wd;
        check("req_ready_idle", req_ready_o, 1);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc > 0) check("req_ready_busy", req_ready_o, 0);
            arready = 0;
            if (arvalid_o) begin
                check("araddr", araddr_o, addr);
                check("arid", arid_o, 1);
                if (ar_w == 0) arready = 1; else ar_w--;
            end
            rvalid = 0;
            if (rready_o) begin
                if (r_w == 0) rvalid = 1; else r_w--;
            end
            rdata = ent ^ {576{~rvalid}};
            wready = 0;
            if (wvalid_o) begin
                check("w_after_aw", aw_done, 1);
                check("wdata", wdata_o, wd);
                check("wid", wid_o, 1);
                if (w_w == 0) wready = 1; else w_w--;
            end
            awready = 0;
            if (awvalid_o) begin
                check("awaddr", awaddr_o, addr);
                check("awid", awid_o, 1);
                if (aw_w == 0) begin awready = 1; aw_done = 1; end else aw_w--;
            end
            bvalid = 0;
            if (bready_o) begin
                b_seen = 1;
                if (b_w == 0) bvalid = 1; else b_w--;
            end
            rsp_ready = 0;
            if (rsp_valid_o) begin
                if (lat < 0) lat = cyc;
                check("rsp_hit", rsp_hit_o, exp_hit);
                check("rsp_data", rsp_data_o, exp_data);
                if (rsp_w == 0) begin rsp_ready = 1; done = 1; end else rsp_w--;
            end
            if (done) req_valid = 1;
            step();
            if (!done) req_valid = 0;
        end
        {arready, rvalid, awready, wready, bvalid, rsp_ready} = '0;
        check("timeout", done, 1);
        check("latency", lat, exp_lat);
        check("idle_after", req_ready_o, 1);
        check("no_reaccept", {arvalid_o, awvalid_o}, 0);
        req_valid = 0;
        if (wr) begin
            check("bready_seen", b_seen, 1);
            if (done) mem[idx] = {1'b1, 1'b1, addr[63:32], 30'($urandom), wd};
        end
        check_stats();
    endtask

    initial begin
        logic [511:0] wd;
        logic [63:0]  a;
        step();
        step();
        check("rst_req_ready", req_ready_o, 1);
        check("rst_valids", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, rsp_valid_o, rsp_hit_o}, 0);
        check("rst_addr_id", {araddr_o, awaddr_o, arid_o, awid_o, wid_o}, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_rsp_data", rsp_data_o, 0);
        check_stats();
        rst_n = 1;
        step();

        // Reset while the write data beat is pending abandons the write.
        req_valid = 1;
        req_write = 1;
        req_addr = 64'h9_0000_00C0;
        req_wdata = rand512();
        step();
        req_valid = 0;
        check("aw_before_rst", awvalid_o, 1);
        awready = 1;
        step();
        awready = 0;
        check("in_w_state", wvalid_o, 1);
        rst_n = 0;
        step();
        check("rst_w_wvalid", wvalid_o, 0);
        check("rst_w_req_ready", req_ready_o, 1);
        check("rst_w_others", {bready_o, awvalid_o, arvalid_o, rsp_valid_o}, 0);
        rst_n = 1;
        step();
        exp_hits = 0;
        exp_misses = 0;

        mem[1] = {1'b1, 1'b0, 32'h0000_0001, 30'h2AAA_AAAA, rand512()};
        txn(0, 64'h1_0000_0040, '0, 0, 0, 0, 0, 0, 0);
        txn(0, 64'h2_0000_0040, '0, 0, 0, 0, 0, 0, 0);
        wd = {64{8'hA5}};
        txn(1, 64'h1_0000_0080, wd, 0, 0, 0, 0, 0, 0);
        txn(0, 64'h1_0000_0080, '0, 0, 0, 0, 0, 0, 0);
        txn(0, 64'h1_0000_0040, '0, 5, 0, 0, 0, 0, 4);
        txn(0, 64'h3_0000_0100, '0, 0, 0, 0, 0, 0, 0);
        check("hits_total", exp_hits, 3);
        check("misses_total", exp_misses, 2);
        mem[5] = {1'b0, 1'b1, 32'h0000_0007, 30'h3FFF_FFFF, rand512()};
        txn(0, 64'h7_0000_0140, '0, 0, 0, 0, 0, 0, 0);
        txn(1, 64'h4_0000_0180, rand512(), 0, 0, 2, 3, 1, 2);

        for (int i = 8; i < 16; i++)
            mem[i] = {1'($urandom), 1'($urandom), 32'($urandom_range(1, 3)), 30'($urandom), rand512()};
        for (int n = 0; n < 40; n++) begin
            a = {32'($urandom_range(1, 3)), 26'($urandom_range(8, 15)), 6'($urandom)};
            txn($urandom_range(0, 2) == 0, a, rand512(),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
